piso_serializer: RTL and testbench

//   Parallel-in serial-out stage that sits directly upstream of the sipo shift register.

---
 rtl/piso_serializer.sv | 107 ++++++++++
 tb/tb_piso_serializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: latches a WIDTH-bit word on a valid/ready handshake and
// shifts it out one bit per clock, with an optional even-parity trailer and inter-frame gap.
module piso_serializer #(
   parameter int WIDTH      = 4,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit PARITY_EN  = 1'b0,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] PREV_IDX  = CNT_W'(WIDTH - 2);
   localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] bit_cnt;
   logic [3:0]       gap_cnt;
   logic             parity_bit;
   logic             accept;

   // Zero-bubble streaming: with no gap, a new word may be taken on the final bit cycle.
   assign in_ready = !rst && ((state == IDLE) || ((GAP_CYCLES == 0) && out_last));
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values; the shift register is reset along with the control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         parity_bit <= 1'b0;
         out        <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else if (accept) begin
         state      <= SHIFT;
         shreg      <= in_data;
         bit_cnt    <= '0;
         parity_bit <= ^in_data;
         out        <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
         out_valid  <= 1'b1;
         out_last   <= 1'b0;
      end else begin
         case (state)
            SHIFT: begin
               if (bit_cnt != LAST_IDX) begin
                  shreg    <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                  out      <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
                  bit_cnt  <= bit_cnt + 1'b1;
                  out_last <= (bit_cnt == PREV_IDX) && !PARITY_EN;
               end else if (PARITY_EN) begin
                  state    <= PARITY;
                  out      <= parity_bit;
                  out_last <= 1'b1;
               end else begin
                  state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
                  gap_cnt   <= '0;
                  out       <= 1'b0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            end
            PARITY: begin
               state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
               gap_cnt   <= '0;
               out       <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               out       <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: four configurations (plain, parity, gap, LSB-first)
// driven by directed and random words, checked bit-by-bit against an expected-frame queue.
module tb_piso_serializer;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   typedef struct packed {
      logic v;
      logic b;
      logic r;
   } log_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] in_data [4];
   logic       in_valid[4];
   logic [3:0] so, ov, ol, rdy, bsy;

   exp_t exp_q[4][$];
   log_t lg[4][$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .GAP_CYCLES(0)) d0 (
      .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(rdy[0]),
      .out(so[0]), .out_valid(ov[0]), .out_last(ol[0]), .busy(bsy[0]));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .GAP_CYCLES(0)) d1 (
      .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(rdy[1]),
      .out(so[1]), .out_valid(ov[1]), .out_last(ol[1]), .busy(bsy[1]));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .GAP_CYCLES(2)) d2 (
      .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(rdy[2]),
      .out(so[2]), .out_valid(ov[2]), .out_last(ol[2]), .busy(bsy[2]));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0), .GAP_CYCLES(0)) d3 (
      .clk(clk), .rst(rst), .in_data(in_data[3]), .in_valid(in_valid[3]), .in_ready(rdy[3]),
      .out(so[3]), .out_valid(ov[3]), .out_last(ol[3]), .busy(bsy[3]));

   function automatic bit msb_of(input int i);
      return i != 3;
   endfunction

   function automatic bit par_of(input int i);
      return i == 1;
   endfunction

   task automatic check(input string name, input int unit, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [d%0d]: got %0h, expected %0h at %0t", name, unit, act, exp, $time);
      end
   endtask

   // Reference frame: data bits in transmit order, then an even-parity bit if enabled.
   task automatic push_exp(input int i, input logic [3:0] w);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.b    = msb_of(i) ? w[3-k] : w[k];
         e.last = (k == 3) && !par_of(i);
         exp_q[i].push_back(e);
      end
      if (par_of(i)) begin
         e.b    = ($countones(w) % 2) == 1;
         e.last = 1'b1;
         exp_q[i].push_back(e);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         lg[i].push_back({ov[i], bsy[i], rdy[i]});
         if (ov[i] === 1'b1) begin
            if (exp_q[i].size() == 0) begin
               check("unexpected_bit", i, 32'(ov[i]), 32'd0);
            end else begin
               exp_t e;
               e = exp_q[i].pop_front();
               check("bit", i, 32'(so[i]), 32'(e.b));
               check("last", i, 32'(ol[i]), 32'(e.last));
            end
         end else begin
            check("idle_out", i, 32'({so[i], ol[i]}), 32'd0);
         end
      end
   end

   task automatic send(input int i, input logic [3:0] w);
      int n = 0;
      @(negedge clk);
      in_data[i]  = w;
      in_valid[i] = 1'b1;
      while (rdy[i] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (rdy[i] !== 1'b1) begin
         check("ready_timeout", i, 32'(n), 32'd0);
         in_valid[i] = 1'b0;
      end else begin
         push_exp(i, w);
         @(posedge clk);
      end
   endtask

   task automatic release_in(input int i);
      @(negedge clk);
      in_valid[i] = 1'b0;
      in_data[i]  = 4'($urandom);
   endtask

   task automatic rand_run(input int i, input int n);
      repeat (n) begin
         int idle = $urandom_range(0, 3);
         repeat (idle) begin
            @(negedge clk);
            in_valid[i] = 1'b0;
            in_data[i]  = 4'($urandom);
         end
         send(i, 4'($urandom));
      end
      release_in(i);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      #1;
      while ((bsy != 4'b0 || exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
              exp_q[3].size() != 0) && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         check("drain_busy", i, 32'(bsy[i]), 32'd0);
         check("drain_queue", i, 32'(exp_q[i].size()), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         in_data[i]  = 4'h0;
         in_valid[i] = 1'b0;
      end
      #1 rst = 1'b1;
      #2;
      for (int i = 0; i < 4; i++) begin
         check("reset_outputs", i, 32'({so[i], ov[i], ol[i], bsy[i]}), 32'd0);
         check("reset_ready", i, 32'(rdy[i]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) check("idle_ready", i, 32'(rdy[i]), 32'd1);

      // Single frames: plain MSB-first, with parity, and LSB-first.
      fork
         begin send(0, 4'b1011); release_in(0); end
         begin send(1, 4'b1011); release_in(1); end
         begin send(3, 4'b0001); release_in(3); end
      join
      wait_idle();

      // Back-to-back words with in_valid held on the no-gap instance.
      lg[0].delete();
      send(0, 4'hA);
      send(0, 4'h5);
      release_in(0);
      wait_idle();
      begin
         int k = 0;
         int run = 0;
         while (k < lg[0].size() && !lg[0][k].v) k++;
         while (k < lg[0].size() && lg[0][k].v) begin run++; k++; end
         check("stream_run", 0, 32'(run), 32'd8);
      end

      // Forced gap between two frames.
      lg[2].delete();
      send(2, 4'hF);
      send(2, 4'h0);
      release_in(2);
      wait_idle();
      begin
         int k = 0;
         int run = 0;
         int gap = 0;
         int bad = 0;
         while (k < lg[2].size() && !lg[2][k].v) k++;
         while (k < lg[2].size() && lg[2][k].v) begin run++; k++; end
         while (k < lg[2].size() && !lg[2][k].v && lg[2][k].b) begin
            gap++;
            if (lg[2][k].r) bad++;
            k++;
         end
         check("frame1_len", 2, 32'(run), 32'd4);
         check("gap_len", 2, 32'(gap), 32'd2);
         check("gap_ready_low", 2, 32'(bad), 32'd0);
      end

      // Randomised traffic on all configurations at once.
      fork
         rand_run(0, 30);
         rand_run(1, 30);
         rand_run(2, 30);
         rand_run(3, 30);
      join
      wait_idle();

      // Reset in the middle of a frame, then a clean frame afterwards.
      send(0, 4'hC);
      release_in(0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_valid", 0, 32'(ov[0]), 32'd0);
      check("abort_busy", 0, 32'(bsy[0]), 32'd0);
      check("abort_ready", 0, 32'(rdy[0]), 32'd0);
      check("abort_bits_seen", 0, 32'(exp_q[0].size()), 32'd2);
      exp_q[0].delete();
      @(negedge clk);
      rst = 1'b0;
      send(0, 4'h3);
      release_in(0);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
